// File: rtl/ball_fsm.sv
// ball_fsm: Pong ball motion controller.
// Consumes the collision checker's bounce code (0 none, 1 paddle, 2 wall,
// 3 score). Owns the ball position and direction, and steps the ball once
// per frame_tick.
//
// Ports:
//   clock        system clock, all logic on posedge
//   reset        synchronous, active-high
//   frame_tick   one-cycle pulse per video frame
//   bounce[1:0]  event code from the collision checker (registered upstream)
//   ball_pos_x   ball left edge (pixels)
//   ball_pos_y   ball top edge (pixels)
//   ball_size_x  constant BALL_SIZE
//   ball_size_y  constant BALL_SIZE
//   dir_x        1 = moving right
//   dir_y        1 = moving down
//   serving      high while the ball rests at centre before a serve
//
// state | meaning
// ------+---------------------------------------------------------------
// SERVE | ball held at centre, counting SERVE_DELAY frames, bounces ignored
// MOVE  | ball steps SPEED px per axis per frame, bounces steer or score
module ball_fsm #(
  parameter int SCREEN_X    = 640,
  parameter int SCREEN_Y    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int SERVE_DELAY = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] bounce,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic [7:0] ball_size_x,
  output logic [7:0] ball_size_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       serving
);

  localparam logic [0:0] SERVE = 1'b0;
  localparam logic [0:0] MOVE  = 1'b1;

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  localparam logic [10:0] MAX_X  = 11'(SCREEN_X - BALL_SIZE);
  localparam logic [10:0] MAX_Y  = 11'(SCREEN_Y - BALL_SIZE);
  localparam logic [10:0] STEP   = 11'(SPEED);
  localparam logic [10:0] HALF_X = 11'(SCREEN_X / 2);
  localparam logic [9:0]  CX     = 10'((SCREEN_X - BALL_SIZE) / 2);
  localparam logic [9:0]  CY     = 10'((SCREEN_Y - BALL_SIZE) / 2);

  logic [0:0]       state;
  logic [CNT_W-1:0] serve_cnt;
  logic [1:0]       bounce_q;
  logic             accept;
  logic             dir_x_nx;
  logic             dir_y_nx;

  // One axis step, computed one bit wider than the position so that
  // neither underflow below 0 nor overflow past the far edge can wrap.
  function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                           input logic        fwd,
                                           input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] r;
    p = {1'b0, pos};
    if (fwd) begin
      r = p + STEP;
      if (r > lim) r = lim;
    end else begin
      if (p < STEP) r = '0;
      else          r = p - STEP;
    end
    return 10'(r);
  endfunction

  // Only a change to a non-zero code counts, so a code held across several
  // cycles (or the one-cycle-stale code upstream) fires exactly once.
  assign accept = (bounce != 2'd0) && (bounce != bounce_q);

  // Steering takes effect before a coincident step.
  assign dir_x_nx = dir_x ^ (accept && (bounce == 2'd1));
  assign dir_y_nx = dir_y ^ (accept && (bounce == 2'd2));

  assign serving     = (state == SERVE);
  assign ball_size_x = 8'(BALL_SIZE);
  assign ball_size_y = 8'(BALL_SIZE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SERVE;
      serve_cnt  <= '0;
      bounce_q   <= 2'd0;
      ball_pos_x <= CX;
      ball_pos_y <= CY;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
    end else begin
      bounce_q <= bounce;
      case (state)
        SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == CNT_LAST) begin
              serve_cnt <= '0;
              state     <= MOVE;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end
        end
        MOVE: begin
          if (accept && (bounce == 2'd3)) begin
            // Score beats a coincident tick; serve away from the exit side.
            state      <= SERVE;
            serve_cnt  <= '0;
            ball_pos_x <= CX;
            ball_pos_y <= CY;
            dir_x      <= ({1'b0, ball_pos_x} < HALF_X);
          end else begin
            dir_x <= dir_x_nx;
            dir_y <= dir_y_nx;
            if (frame_tick) begin
              ball_pos_x <= step_axis(ball_pos_x, dir_x_nx, MAX_X);
              ball_pos_y <= step_axis(ball_pos_y, dir_y_nx, MAX_Y);
            end
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_fsm.sv
module tb_ball_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_tick, frame_tick2;
  logic [1:0] bounce, bounce2;

  logic [9:0] pos_x, pos_y, pos_x2, pos_y2;
  logic [7:0] size_x, size_y, size_x2, size_y2;
  logic       dx, dy, srv, dx2, dy2, srv2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  ball_fsm dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .bounce(bounce),
    .ball_pos_x(pos_x), .ball_pos_y(pos_y),
    .ball_size_x(size_x), .ball_size_y(size_y),
    .dir_x(dx), .dir_y(dy), .serving(srv)
  );

  // Odd speed and minimum serve delay reach positions the default cannot.
  ball_fsm #(.SPEED(3), .SERVE_DELAY(1)) dut3 (
    .clock(clock), .reset(reset), .frame_tick(frame_tick2), .bounce(bounce2),
    .ball_pos_x(pos_x2), .ball_pos_y(pos_y2),
    .ball_size_x(size_x2), .ball_size_y(size_y2),
    .dir_x(dx2), .dir_y(dy2), .serving(srv2)
  );

  typedef struct {
    logic       tick;
    logic [1:0] code;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       edx;
    logic       edy;
    logic       es;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [22:0] act,
                       input logic [9:0] ex, input logic [9:0] ey,
                       input logic edx, input logic edy, input logic es);
    logic [22:0] exp;
    exp = {ex, ey, edx, edy, es};
    n_checks++;
    if (act === exp) n_pass++;
    else
      $display("FAIL %s: got x=%0d y=%0d dx=%0d dy=%0d serving=%0d, expected x=%0d y=%0d dx=%0d dy=%0d serving=%0d",
               name, act[22:13], act[12:3], act[2], act[1], act[0],
               ex, ey, edx, edy, es);
  endtask

  function automatic logic [22:0] st1();
    return {pos_x, pos_y, dx, dy, srv};
  endfunction

  function automatic logic [22:0] st3();
    return {pos_x2, pos_y2, dx2, dy2, srv2};
  endfunction

  task automatic cyc(input logic t, input logic [1:0] b);
    frame_tick = t;
    bounce     = b;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, bounce);
      cyc(1'b0, bounce);
    end
  endtask

  task automatic cyc3(input logic t, input logic [1:0] b);
    frame_tick2 = t;
    bounce2     = b;
    @(posedge clock);
    #1;
    frame_tick2 = 1'b0;
  endtask

  task automatic ticks3(input int n);
    for (int i = 0; i < n; i++) begin
      cyc3(1'b1, bounce2);
      cyc3(1'b0, bounce2);
    end
  endtask

  initial begin
    // Starting from 318/234, dir_x=1, dir_y=0, in MOVE.
    tbl[0]  = '{1'b1, 2'd0, 10'd320, 10'd232, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 10'd320, 10'd232, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 10'd322, 10'd234, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 10'd322, 10'd234, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'd1, 10'd320, 10'd236, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 10'd320, 10'd236, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 10'd318, 10'd234, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 10'd318, 10'd234, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'd3, 10'd316, 10'd236, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 10'd316, 10'd236, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 2'd2, 10'd316, 10'd236, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 10'd316, 10'd236, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; frame_tick = 1'b0; bounce = 2'd0;
    frame_tick2 = 1'b0; bounce2 = 2'd0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;

    check("reset", st1(), 10'd316, 10'd236, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({size_x, size_y} === 16'h0808) n_pass++;
    else $display("FAIL ball_size: got %0d/%0d, expected 8/8", size_x, size_y);

    // Serve timing.
    ticks(59);
    check("serve_59", st1(), 10'd316, 10'd236, 1'b1, 1'b1, 1'b1);
    ticks(1);
    check("serve_60", st1(), 10'd316, 10'd236, 1'b1, 1'b1, 1'b0);
    ticks(1);
    check("first_step", st1(), 10'd318, 10'd238, 1'b1, 1'b1, 1'b0);

    // Held wall code spanning three ticks.
    for (int i = 0; i < 20; i++) begin
      cyc((i == 4) || (i == 9) || (i == 14), 2'd2);
      if (i == 0) check("wall_toggle", st1(), 10'd318, 10'd238, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 2'd0);
    check("wall_held", st1(), 10'd324, 10'd232, 1'b1, 1'b0, 1'b0);

    // Paddle coinciding with a tick at x=100 moving left.
    cyc(1'b0, 2'd1);
    cyc(1'b0, 2'd0);
    ticks(112);
    check("at_100", st1(), 10'd100, 10'd8, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd1);
    check("paddle_tick", st1(), 10'd102, 10'd6, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 2'd0);

    // Top clamp at 0 with no wrap.
    ticks(3);
    check("top_reach", st1(), 10'd108, 10'd0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check("top_clamp", st1(), 10'd110, 10'd0, 1'b1, 1'b0, 1'b0);

    // Score from the left side, code held two cycles.
    cyc(1'b0, 2'd1);
    cyc(1'b0, 2'd0);
    ticks(53);
    check("at_4", st1(), 10'd4, 10'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'd3);
    check("score", st1(), 10'd316, 10'd236, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 2'd3);
    check("score_held", st1(), 10'd316, 10'd236, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 2'd0);
    ticks(59);
    check("reserve_59", st1(), 10'd316, 10'd236, 1'b1, 1'b0, 1'b1);
    ticks(1);
    check("reserve_60", st1(), 10'd316, 10'd236, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check("reserve_step", st1(), 10'd318, 10'd234, 1'b1, 1'b0, 1'b0);

    // Per-cycle vectors: held codes, simultaneous events, score vs tick.
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].tick, tbl[i].code);
      check($sformatf("vec%0d", i), st1(), tbl[i].ex, tbl[i].ey,
            tbl[i].edx, tbl[i].edy, tbl[i].es);
    end

    // Reset mid-move at x=400 moving left.
    ticks(60);
    check("vec_serve_end", st1(), 10'd316, 10'd236, 1'b1, 1'b0, 1'b0);
    ticks(42);
    cyc(1'b0, 2'd1);
    cyc(1'b0, 2'd0);
    check("at_400", st1(), 10'd400, 10'd152, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 2'd0);
    reset = 1'b0;
    check("reset_move", st1(), 10'd316, 10'd236, 1'b1, 1'b1, 1'b1);

    // Reset mid-serve restarts the serve counter.
    ticks(30);
    reset = 1'b1;
    cyc(1'b0, 2'd0);
    reset = 1'b0;
    ticks(59);
    check("reset_serve_59", st1(), 10'd316, 10'd236, 1'b1, 1'b1, 1'b1);
    ticks(1);
    check("reset_serve_60", st1(), 10'd316, 10'd236, 1'b1, 1'b1, 1'b0);

    // SPEED=3, SERVE_DELAY=1 instance (it was idle and reset above).
    check("d3_reset", st3(), 10'd316, 10'd236, 1'b1, 1'b1, 1'b1);
    ticks3(1);
    check("d3_serve", st3(), 10'd316, 10'd236, 1'b1, 1'b1, 1'b0);
    ticks3(78);
    check("d3_at_470", st3(), 10'd550, 10'd470, 1'b1, 1'b1, 1'b0);
    ticks3(1);
    check("d3_bottom_clamp", st3(), 10'd553, 10'd472, 1'b1, 1'b1, 1'b0);
    cyc3(1'b0, 2'd1);
    cyc3(1'b0, 2'd0);
    ticks3(184);
    check("d3_at_1", st3(), 10'd1, 10'd472, 1'b0, 1'b1, 1'b0);
    ticks3(1);
    check("d3_left_clamp", st3(), 10'd0, 10'd472, 1'b0, 1'b1, 1'b0);
    ticks3(1);
    check("d3_left_hold", st3(), 10'd0, 10'd472, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ball_fsm.md
# ball_fsm

Ball motion controller for Pong. Sits directly downstream of the collision/score checker and consumes its 2-bit `bounce` event code: 0 none, 1 paddle, 2 wall, 3 score. Owns the ball position and direction registers, advancing the ball once per video frame. Its `ball_pos_*`/`ball_size_*` outputs feed back into the collision checker and the renderer.

## Interface
- `SCREEN_X`, 640, screen width in pixels
- `SCREEN_Y`, 480, screen height in pixels
- `BALL_SIZE`, 8, ball edge length in pixels, square; must be ≤ 255
- `SPEED`, 2, pixels moved per axis per frame; must be ≥ 1
- `SERVE_DELAY`, 60, frames the ball rests at centre before each serve; must be ≥ 1

Ports:
- `clock`  in  1  system clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `frame_tick`  in  1  one-cycle pulse per frame
- `bounce`  in  2  event code from the collision checker, registered upstream
- `ball_pos_x`  out  10  ball left edge, in pixels
- `ball_pos_y`  out  10  ball top edge, in pixels
- `ball_size_x`  out  8  constant `BALL_SIZE`
- `ball_size_y`  out  8  constant `BALL_SIZE`
- `dir_x`  out  1  1 = moving right (+x), 0 = moving left
- `dir_y`  out  1  1 = moving down (+y), 0 = moving up
- `serving`  out  1  high while in state SERVE

## Operation
- Centre position:
  - CX = (SCREEN_X − BALL_SIZE)/2, which is 316 by default.
  - CY = (SCREEN_Y − BALL_SIZE)/2, which is 236 by default.
- Reset values: state SERVE, `ball_pos_x`=CX, `ball_pos_y`=CY, `dir_x`=1, `dir_y`=1, serve counter 0, `bounce_q`=0, `serving`=1.
- Edge detection:
  - `bounce_q` registers `bounce` every cycle.
  - An event is accepted only when `bounce` ≠ 0 and `bounce` ≠ `bounce_q`.
  - A code held for many cycles therefore produces exactly one action.
- State SERVE:
  - Position is held at the centre.
  - `bounce` events are ignored, but `bounce_q` still tracks.
  - Each `frame_tick` increments the serve counter.
  - A tick arriving with counter = SERVE_DELAY−1 clears the counter and moves to MOVE. No movement happens on that tick.
- State MOVE:
  - Accepted code 1 (paddle): toggle `dir_x`.
  - Accepted code 2 (wall): toggle `dir_y`.
  - Accepted code 3 (score): move to SERVE, load the centre position, clear the counter, and keep `dir_y`.
    - Set `dir_x` = 1 if the pre-event `ball_pos_x` < SCREEN_X/2; otherwise set `dir_x` = 0. The ball is served away from the side it exited.
  - On `frame_tick`, step each axis by SPEED in its direction.
- Step arithmetic:
  - Compute in 11 bits so there is no wrap.
  - Moving left/up: if pos < SPEED, result is 0.
  - Moving right/down: if pos + SPEED > SCREEN − BALL_SIZE, result is SCREEN − BALL_SIZE.
  - Otherwise the result is pos ± SPEED.
- Simultaneous events:
  - Paddle or wall event together with `frame_tick`: apply the toggled direction first, and the step in the same cycle uses the new direction.
  - Score event together with `frame_tick`: score wins; the centre is loaded and no step occurs.
- `reset` overrides everything in any state, including mid-serve and mid-move.

## Timing
- All outputs are registered and change only on `clock` posedge.
- Position updates on the edge at which `frame_tick` is sampled high. Latency is 1 cycle from the tick.
- Direction updates 1 cycle after the new `bounce` code is presented.
- `serving` rises 1 cycle after an accepted score and falls 1 cycle after the final serve tick.
- Upstream `bounce` lags position by 1 cycle. Edge detection keeps that stale code, plus any code held over several frames, from re-firing.
- `frame_tick` must not be high on consecutive cycles. Behaviour in that case is still a defined step per tick, with no extra handling.

## Test plan
- Serve timing:
  - Stimulus: reset, then 60 ticks.
  - Response: position 316/236 and `serving`=1 throughout.
  - Stimulus: tick 61.
  - Response: x=318, y=238, `serving`=0.
- Held wall code:
  - Stimulus: in MOVE with `dir_y`=1, hold `bounce`=2 for 20 cycles spanning 3 ticks.
  - Response: `dir_y`=0 after exactly 1 toggle; y decreases by 2 per tick.
- Paddle code coinciding with a tick:
  - Stimulus: x=100, `dir_x`=0, `bounce` goes 0→1 on the same cycle as `frame_tick`.
  - Response: `dir_x`=1 and x=102.
- Score:
  - Stimulus: x=4 moving left, `bounce`=3 for 2 cycles.
  - Response: one recentre to 316/236, `dir_x`=1, `serving`=1, counter restarts.
- Clamping:
  - Stimulus: y=471 moving down, tick.
  - Response: y=472.
  - Stimulus: x=1 moving left, tick.
  - Response: x=0, with no wrap to 1023.
- Reset mid-move:
  - Stimulus: assert `reset` one cycle at x=400, `dir_x`=0.
  - Response: next cycle x=316, `dir_x`=1, `serving`=1.
